// File: rtl/smi_frame_store_fwd.sv
// ---------------------------------------------------------------------------
// smi_frame_store_fwd
//
// Store-and-forward buffer for SMI request flits, placed directly in front of
// the SMI/AXI adaptor's request input. A frame is only released downstream
// once its final flit has been buffered, so the adaptor never sees a burst
// stall half way through. If a single frame is larger than the buffer, the
// block falls back to cut-through until that frame's final flit has left.
// This fallback prevents the buffer from deadlocking.
//
// Ports:
//   clk          clock, rising edge
//   srst         asynchronous active-high reset
//   smiInReady   upstream flit valid
//   smiInEofc    upstream end-of-frame / byte count (0 = non-final flit)
//   smiInData    upstream flit data
//   smiInStop    backpressure to upstream (buffer full)
//   smiOutReady  downstream flit valid
//   smiOutEofc   downstream end-of-frame / byte count
//   smiOutData   downstream flit data
//   smiOutStop   backpressure from downstream
//   fillLevel    flits currently held
//   frameCount   complete frames currently held
//   cutThrough   high while an oversize frame is being forwarded
// ---------------------------------------------------------------------------
module smi_frame_store_fwd #(
  parameter int FlitWidth     = 16,
  parameter int FifoIndexSize = 6
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       smiInReady,
  input  logic [7:0]                 smiInEofc,
  input  logic [FlitWidth*8-1:0]     smiInData,
  output logic                       smiInStop,
  output logic                       smiOutReady,
  output logic [7:0]                 smiOutEofc,
  output logic [FlitWidth*8-1:0]     smiOutData,
  input  logic                       smiOutStop,
  output logic [FifoIndexSize:0]     fillLevel,
  output logic [FifoIndexSize:0]     frameCount,
  output logic                       cutThrough
);

  localparam int FifoDepth  = 1 << FifoIndexSize;
  localparam int DataWidth  = FlitWidth * 8;
  localparam int EntryWidth = DataWidth + 8;
  localparam logic [FifoIndexSize:0] FullLevel = (FifoIndexSize+1)'(FifoDepth);

  typedef enum logic [0:0] {
    Store = 1'b0,
    Cut   = 1'b1
  } stateT;

  logic [EntryWidth-1:0]    mem [FifoDepth];
  logic [FifoIndexSize-1:0] wrPtr;
  logic [FifoIndexSize-1:0] rdPtr;
  logic [FifoIndexSize:0]   fillNext;
  logic [FifoIndexSize:0]   frameNext;
  stateT                    state;
  stateT                    stateNext;
  logic                     pushEn;
  logic                     popEn;
  logic                     pushEof;
  logic                     popEof;

  // Status and handshake outputs come only from registered state, so neither
  // Ready depends combinationally on the Stop of the same port.
  assign smiInStop   = (fillLevel == FullLevel);
  assign cutThrough  = (state == Cut);
  assign smiOutReady = (fillLevel != {(FifoIndexSize+1){1'b0}}) &&
                       ((frameCount != {(FifoIndexSize+1){1'b0}}) || cutThrough);
  assign smiOutEofc  = mem[rdPtr][EntryWidth-1 -: 8];
  assign smiOutData  = mem[rdPtr][DataWidth-1:0];

  // Handshakes, occupancy bookkeeping and cut-through state decision.
  always_comb begin
    pushEn    = smiInReady && !smiInStop;
    popEn     = smiOutReady && !smiOutStop;
    pushEof   = pushEn && (smiInEofc != 8'd0);
    popEof    = popEn && (smiOutEofc != 8'd0);
    fillNext  = fillLevel;
    frameNext = frameCount;
    stateNext = state;

    case ({pushEn, popEn})
      2'b10:   fillNext = fillLevel + (FifoIndexSize+1)'(1);
      2'b01:   fillNext = fillLevel - (FifoIndexSize+1)'(1);
      default: fillNext = fillLevel;
    endcase

    // A final flit pushed and another popped in the same cycle cancel out.
    case ({pushEof, popEof})
      2'b10:   frameNext = frameCount + (FifoIndexSize+1)'(1);
      2'b01:   frameNext = frameCount - (FifoIndexSize+1)'(1);
      default: frameNext = frameCount;
    endcase

    // Full buffer holding no complete frame means one frame is larger than
    // the buffer; forward it as it arrives until its final flit leaves.
    case (state)
      Store: begin
        if ((fillLevel == FullLevel) && (frameCount == {(FifoIndexSize+1){1'b0}})) begin
          stateNext = Cut;
        end else begin
          stateNext = Store;
        end
      end
      Cut: begin
        if (popEof) begin
          stateNext = Store;
        end else begin
          stateNext = Cut;
        end
      end
      default: stateNext = Store;
    endcase
  end

  // Pointer, counter and state registers; any partial frame is dropped on reset.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wrPtr      <= {FifoIndexSize{1'b0}};
      rdPtr      <= {FifoIndexSize{1'b0}};
      fillLevel  <= {(FifoIndexSize+1){1'b0}};
      frameCount <= {(FifoIndexSize+1){1'b0}};
      state      <= Store;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + FifoIndexSize'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + FifoIndexSize'(1);
      end
      fillLevel  <= fillNext;
      frameCount <= frameNext;
      state      <= stateNext;
    end
  end

  // Flit storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtr] <= {smiInEofc, smiInData};
    end
  end

endmodule

// File: tb/tb_smi_frame_store_fwd.sv
// ---------------------------------------------------------------------------
// Bench for smi_frame_store_fwd. A flit queue in the bench models the buffer.
// Expected handshakes, counts and the cut-through flag are derived from the
// queue's contents each cycle, and each output flit is compared against the
// head of that queue.
// ---------------------------------------------------------------------------
module tb_smi_frame_store_fwd;

  localparam int Depth = 64;

  logic         clk = 1'b0;
  logic         srst;
  logic         smiInReady;
  logic [7:0]   smiInEofc;
  logic [127:0] smiInData;
  logic         smiInStop;
  logic         smiOutReady;
  logic [7:0]   smiOutEofc;
  logic [127:0] smiOutData;
  logic         smiOutStop;
  logic [6:0]   fillLevel;
  logic [6:0]   frameCount;
  logic         cutThrough;

  int checkCnt = 0;
  int passCnt  = 0;

  logic [135:0] sbQ[$];
  bit           modelCut   = 1'b0;
  bit           inFireFlag = 1'b0;

  smi_frame_store_fwd #(.FlitWidth(16), .FifoIndexSize(6)) dut (
    .clk(clk), .srst(srst),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData),
    .smiInStop(smiInStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData),
    .smiOutStop(smiOutStop),
    .fillLevel(fillLevel), .frameCount(frameCount), .cutThrough(cutThrough)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int modelFrames();
    int n = 0;
    foreach (sbQ[i]) if (sbQ[i][135:128] != 8'd0) n++;
    return n;
  endfunction

  // Monitor and reference model. It samples on the falling edge and
  // advances the model to the state expected after the next rising edge.
  always @(negedge clk) begin
    int  fl;
    int  fr;
    bit  mStop;
    bit  mReady;
    bit  outFire;
    bit  inFire;
    bit  nextCut;
    if (srst) begin
      inFireFlag = 1'b0;
    end else begin
      fl     = sbQ.size();
      fr     = modelFrames();
      mStop  = (fl == Depth);
      mReady = (fl != 0) && (fr != 0 || modelCut);
      chk("inStop",     136'(smiInStop),   136'(mStop));
      chk("outReady",   136'(smiOutReady), 136'(mReady));
      chk("fillLevel",  136'(fillLevel),   136'(fl));
      chk("frameCount", 136'(frameCount),  136'(fr));
      chk("cutThrough", 136'(cutThrough),  136'(modelCut));
      if (mReady) chk("outFlit", {smiOutEofc, smiOutData}, sbQ[0]);
      outFire = mReady && !smiOutStop;
      inFire  = smiInReady && !mStop;
      if (modelCut) nextCut = !(outFire && sbQ[0][135:128] != 8'd0);
      else          nextCut = (fl == Depth) && (fr == 0);
      if (outFire) void'(sbQ.pop_front());
      if (inFire)  sbQ.push_back({smiInEofc, smiInData});
      modelCut   = nextCut;
      inFireFlag = inFire;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one flit and hold it until the model reports it was accepted.
  task automatic sendFlit(input logic [7:0] e, input logic [127:0] d);
    smiInReady = 1'b1;
    smiInEofc  = e;
    smiInData  = d;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      #1;
      if (inFireFlag) begin
        smiInReady = 1'b0;
        return;
      end
    end
    smiInReady = 1'b0;
    chk("sendTimeout", 136'(1), 136'(0));
  endtask

  task automatic drain();
    smiOutStop = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (sbQ.size() == 0 && !modelCut) return;
      idle(1);
    end
    chk("drainTimeout", 136'(sbQ.size()), 136'(0));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    srst = 1'b1; smiInReady = 1'b0; smiInEofc = 8'd0; smiInData = 128'd0; smiOutStop = 1'b0;
    #1;
    chk("rstOutReady",   136'(smiOutReady), 136'(0));
    chk("rstInStop",     136'(smiInStop),   136'(0));
    chk("rstFill",       136'(fillLevel),   136'(0));
    chk("rstFrames",     136'(frameCount),  136'(0));
    chk("rstCut",        136'(cutThrough),  136'(0));
    idle(3);
    srst = 1'b0;
    idle(1);

    // 3-flit frame, downstream open.
    sendFlit(8'd0,  128'hA);
    sendFlit(8'd0,  128'hB);
    sendFlit(8'd16, 128'hC);
    drain();

    // Two 2-flit frames held back, then released.
    smiOutStop = 1'b1;
    sendFlit(8'd0, 128'h11); sendFlit(8'd4, 128'h12);
    sendFlit(8'd0, 128'h21); sendFlit(8'd9, 128'h22);
    idle(10);
    drain();

    // Fill with 16 complete 4-flit frames, then pop a single flit.
    smiOutStop = 1'b1;
    for (int f = 0; f < 16; f++)
      for (int k = 0; k < 4; k++)
        sendFlit((k == 3) ? 8'd16 : 8'd0, 128'(f * 4 + k));
    idle(3);
    smiOutStop = 1'b0;
    idle(1);
    smiOutStop = 1'b1;
    idle(2);
    drain();

    // Oversize 70-flit frame forces cut-through.
    for (int k = 0; k < 70; k++)
      sendFlit((k == 69) ? 8'd5 : 8'd0, rnd128());
    drain();

    // Push of frame 2's final flit in the same cycle as frame 1's final pop.
    smiOutStop = 1'b1;
    sendFlit(8'd0, 128'h51); sendFlit(8'd3, 128'h52);
    sendFlit(8'd0, 128'h61);
    smiOutStop = 1'b0;
    idle(1);
    sendFlit(8'd7, 128'h62);
    drain();

    // Reset in the middle of a frame.
    smiOutStop = 1'b0;
    sendFlit(8'd0, 128'h71); sendFlit(8'd0, 128'h72);
    srst = 1'b1;
    #1;
    chk("midRstOutReady", 136'(smiOutReady), 136'(0));
    chk("midRstFill",     136'(fillLevel),   136'(0));
    chk("midRstFrames",   136'(frameCount),  136'(0));
    chk("midRstInStop",   136'(smiInStop),   136'(0));
    sbQ.delete();
    modelCut = 1'b0;
    idle(2);
    srst = 1'b0;
    sendFlit(8'd8, 128'h81);
    drain();

    // Randomised traffic with random downstream backpressure.
    fork
      begin
        repeat (1500) begin
          @(posedge clk);
          #1;
          smiOutStop = ($urandom_range(0, 3) == 0);
        end
        smiOutStop = 1'b0;
      end
      begin
        for (int n = 0; n < 400; n++) begin
          sendFlit(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 16)) : 8'd0, rnd128());
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        sendFlit(8'd1, rnd128());
      end
    join
    drain();
    idle(2);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
